// File: rtl/rtc_master.sv
// Serial master for a 3-wire RTC: one command byte followed by one data byte
// (written or read), framed by chip select and a free-running-per-bit serial clock.
module rtc_master #(
  parameter int HALF = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rtc_cs_n,
  output logic       rtc_ck,
  output logic       rtc_dat_o,
  output logic       rtc_dat_oe,
  input  logic       rtc_dat_i
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, HOLD, RECOVER} state_t;

  localparam logic [7:0] HALF_M1 = 8'(HALF - 1);

  state_t      state_q, state_d;
  logic [7:0]  half_q, half_d;
  logic [3:0]  bit_q, bit_d;
  logic        ck_q, ck_d;
  logic [15:0] tx_q, tx_d;
  logic        rd_q, rd_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        last;

  assign last = (half_q == HALF_M1);

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    ck_d    = ck_q;
    tx_d    = tx_q;
    rd_d    = rd_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    sync1_d = rtc_dat_i;
    sync2_d = sync1_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CMD;
          half_d  = 8'd0;
          bit_d   = 4'd0;
          ck_d    = 1'b0;
          tx_d    = {cmd, wdata};
          rd_d    = cmd[7];
        end
      end
      CMD, DATA: begin
        // Read data is captured on the final low-phase cycle, just before ck rises.
        if (state_q == DATA && rd_q && !ck_q && last)
          rx_d = {rx_q[6:0], sync2_q};
        if (last) begin
          half_d = 8'd0;
          if (!ck_q) begin
            ck_d = 1'b1;
          end else begin
            ck_d  = 1'b0;
            tx_d  = {tx_q[14:0], 1'b1};
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd7)  state_d = DATA;
            if (bit_q == 4'd15) state_d = HOLD;
          end
        end else begin
          half_d = half_q + 8'd1;
        end
      end
      HOLD: begin
        if (last) begin
          state_d = RECOVER;
          half_d  = 8'd0;
        end else begin
          half_d = half_q + 8'd1;
        end
      end
      RECOVER: begin
        if (last) begin
          state_d = IDLE;
          half_d  = 8'd0;
          done_d  = 1'b1;
          if (rd_q) rdata_d = rx_q;
        end else begin
          half_d = half_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      half_q  <= 8'd0;
      bit_q   <= 4'd0;
      ck_q    <= 1'b0;
      tx_q    <= 16'd0;
      rd_q    <= 1'b0;
      rx_q    <= 8'd0;
      rdata_q <= 8'd0;
      done_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      ck_q    <= ck_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign rtc_cs_n   = (state_q == IDLE) || (state_q == RECOVER);
  assign rtc_ck     = ck_q;
  assign rtc_dat_oe = (state_q == CMD) || (state_q == DATA && !rd_q);
  assign rtc_dat_o  = rtc_dat_oe ? tx_q[15] : 1'b1;

endmodule
